univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the lab storage elements: a WIDTH-bit edge-triggered universal register with four modes (hold, shift left, shift right, parallel load).
- Provides complementary outputs q_o/notq_o and serial outputs for chaining.
- Includes a saturating shift counter with a done flag, so a serialiser built from this block knows when a full word has been shifted out.
- Standalone lab block; instances can be chained via the serial pins.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 1.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits.
- CW, $clog2(WIDTH+1), counter width. Derived; not to be overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- mode_i  in  2  operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- d_i  in  WIDTH  parallel load data.
- sl_i  in  1  serial input entering bit 0 on shift left.
- sr_i  in  1  serial input entering bit WIDTH-1 on shift right.
- q_o  out  WIDTH  register contents.
- notq_o  out  WIDTH  bitwise complement of q_o.
- so_l_o  out  1  q_o[WIDTH-1]; serial out for left-shift chains.
- so_r_o  out  1  q_o[0]; serial out for right-shift chains.
- cnt_o  out  CW  shifts performed since the last load or reset, saturating at WIDTH.
- done_o  out  1  high when cnt_o == WIDTH.

Behaviour:

Reset:
- rst_i high immediately forces q = RESET_VAL and cnt = 0, independent of clk_i.
- Outputs during and after reset: notq_o = ~RESET_VAL, done_o = 0.
- Reset dominates any mode_i value.
- Reset asserted mid-shift-sequence discards the sequence; the first edge after release acts on the current mode_i.

Register update (one rising edge, latency 1 cycle, no handshake):
- 00: q unchanged.
- 01: q <= {q[WIDTH-2:0], sl_i}.
- 10: q <= {sr_i, q[WIDTH-1:1]}.
- 11: q <= d_i.
- WIDTH==1: both shift modes load the single bit from sl_i or sr_i respectively.

Derived outputs:
- notq_o, so_l_o, so_r_o and done_o are purely combinational from registered state; no input-to-output combinational path.

Counter:
- 11 (load): cnt <= 0.
- 01 or 10 (shift): cnt <= cnt+1 if cnt < WIDTH, else holds at WIDTH. No wrap-around.
- 00 (hold): cnt unchanged.
- Mixing left and right shifts counts each shift; direction is not tracked.
- done_o stays high through further shifts and holds; only a load or reset clears it.

Inputs sampled only at rising edges; glitches between edges have no effect (unlike a level-sensitive latch).

Optional Feature:
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- Defined: shift modes rotate instead of shift; sl_i and sr_i are ignored.
  - 01: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 10: q <= {q[0], q[WIDTH-1:1]}.
  - Counter and done_o behave identically; after WIDTH rotations q equals its loaded value.
- Undefined: serial-input behaviour as specified above; sl_i and sr_i are used.

Test Plan (WIDTH=8, RESET_VAL=0):
- Reset: rst_i=1 with no clock edge -> q_o=0x00, notq_o=0xFF, cnt_o=0, done_o=0. Release, mode 00 for 3 edges -> unchanged.
- Load then hold: mode 11, d_i=0xA5, 1 edge -> q_o=0xA5, notq_o=0x5A, so_l_o=1, so_r_o=1, cnt_o=0. Mode 00 for 4 edges -> still 0xA5.
- Shift left: load 0x81, mode 01, sl_i=0, 1 edge -> q_o=0x02, cnt_o=1. 7 more edges -> q_o=0x00, cnt_o=8, done_o=1. 2 further edges -> cnt_o stays 8, done_o stays 1.
- Shift right serial fill: load 0x00, mode 10, sr_i=1, 8 edges -> q_o=0xFF, done_o=1. Mode 11 with d_i=0x3C -> q_o=0x3C, cnt_o=0, done_o=0.
- Async reset mid-sequence: load 0xF0, 3 left shifts (cnt_o=3), pulse rst_i between edges -> q_o=0x00 and cnt_o=0 before the next edge.
- With UNIV_SHIFT_REG_ROTATE_EN: load 0x81, mode 01, sl_i=0, 1 edge -> q_o=0x03. Mode 10 for 1 edge -> q_o=0x81. 8 rotations total -> value restored, done_o=1.

Source files
------------

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Purpose  : WIDTH-bit universal register (hold / shift left / shift right /
//             parallel load). It has complementary and serial outputs, and a
//             saturating shift counter with a done flag for serialisers.
//  Option   : `define UNIV_SHIFT_REG_ROTATE_EN makes both shift modes rotate.
//             sl_i and sr_i are then ignored.
//  Revision : 1.0  initial release
// ============================================================================
module univ_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sl_i,
    input  logic             sr_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] notq_o,
    output logic             so_l_o,
    output logic             so_r_o,
    output logic [CW-1:0]    cnt_o,
    output logic             done_o
);

    localparam logic [1:0]    c_MODE_HOLD  = 2'b00;
    localparam logic [1:0]    c_MODE_SHL   = 2'b01;
    localparam logic [1:0]    c_MODE_SHR   = 2'b10;
    localparam logic [1:0]    c_MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] c_CNT_FULL   = CW'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic             w_fill_l;
    logic             w_fill_r;
    logic             w_is_shift;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // Rotation: the bit leaving one end re-enters at the other end
    assign w_fill_l = r_q[WIDTH-1];
    assign w_fill_r = r_q[0];
`else
    // Serial fill from the chaining inputs
    assign w_fill_l = sl_i;
    assign w_fill_r = sr_i;
`endif

    // A single-bit register has no body to shift, so it just takes the fill bit
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shl = w_fill_l;
            assign w_shr = w_fill_r;
        end else begin : g_wn
            assign w_shl = {r_q[WIDTH-2:0], w_fill_l};
            assign w_shr = {w_fill_r, r_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_is_shift = (mode_i == c_MODE_SHL) || (mode_i == c_MODE_SHR);

    // Register contents: reset dominates, otherwise the mode selects the next value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= RESET_VAL;
        end else begin
            case (mode_i)
                c_MODE_HOLD: r_q <= r_q;
                c_MODE_SHL:  r_q <= w_shl;
                c_MODE_SHR:  r_q <= w_shr;
                c_MODE_LOAD: r_q <= d_i;
                default:     r_q <= r_q;
            endcase
        end
    end

    // Shift counter: cleared by load, saturates at WIDTH, direction-agnostic
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (mode_i == c_MODE_LOAD) begin
            r_cnt <= '0;
        end else if (w_is_shift && (r_cnt < c_CNT_FULL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Derived outputs depend only on registered state
    assign q_o    = r_q;
    assign notq_o = ~r_q;
    assign so_l_o = r_q[WIDTH-1];
    assign so_r_o = r_q[0];
    assign cnt_o  = r_cnt;
    assign done_o = (r_cnt == c_CNT_FULL);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_univ_shift_reg
//  Purpose  : Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic [1:0]       mode   = 2'b00;
    logic [WIDTH-1:0] d      = '0;
    logic             sl     = 1'b0;
    logic             sr     = 1'b0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] notq;
    logic             so_l;
    logic             so_r;
    logic [CW-1:0]    cnt;
    logic             done;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .mode_i (mode),
        .d_i    (d),
        .sl_i   (sl),
        .sr_i   (sr),
        .q_o    (q),
        .notq_o (notq),
        .so_l_o (so_l),
        .so_r_o (so_r),
        .cnt_o  (cnt),
        .done_o (done)
    );

    always #5 clk = ~clk;

    // Push an expectation; the monitor compares it in the same time step
    task automatic expect_st(input string nm, input logic [7:0] eq,
                             input logic [3:0] ec, input logic ed);
        exp_t e;
        e.name = nm; e.q = eq; e.cnt = ec; e.done = ed;
        sb.push_back(e);
        #1;
    endtask

    // Apply inputs away from the edge, then step past one rising edge
    task automatic step(input logic [1:0] m, input logic [7:0] dv,
                        input logic l, input logic r);
        @(negedge clk);
        mode = m; d = dv; sl = l; sr = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops each expectation and checks every output against it
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() > 0);
            e = sb.pop_front();
            n_cmp++;
            if (q !== e.q || notq !== ~e.q || so_l !== e.q[7] || so_r !== e.q[0] ||
                cnt !== e.cnt || done !== e.done) begin
                n_bad++;
                $display("FAIL %s: got q=%h notq=%h sol=%b sor=%b cnt=%0d done=%b, want q=%h notq=%h sol=%b sor=%b cnt=%0d done=%b",
                         e.name, q, notq, so_l, so_r, cnt, done,
                         e.q, ~e.q, e.q[7], e.q[0], e.cnt, e.done);
            end
        end
    end

    // Hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl_l [8];
        logic [7:0] tbl_r [8];
        logic [7:0] tbl_rot [8];
        tbl_l   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
        tbl_r   = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        tbl_rot = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

        // Asynchronous reset before any rising edge
        #1 rst = 1'b1;
        #2;
        expect_st("reset_no_clk", 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 8'h00, 1'b0, 1'b0);
            expect_st("reset_hold", 8'h00, 4'd0, 1'b0);
        end

        // Load then hold
        step(2'b11, 8'hA5, 1'b0, 1'b0);
        expect_st("load_a5", 8'hA5, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 8'h00, 1'b1, 1'b1);
            expect_st("hold_a5", 8'hA5, 4'd0, 1'b0);
        end

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        // Rotate left then right undoes itself; serial inputs ignored
        step(2'b11, 8'h81, 1'b0, 1'b0);
        expect_st("rot_load", 8'h81, 4'd0, 1'b0);
        step(2'b01, 8'h00, 1'b0, 1'b0);
        expect_st("rot_left1", 8'h03, 4'd1, 1'b0);
        step(2'b10, 8'h00, 1'b0, 1'b0);
        expect_st("rot_right1", 8'h81, 4'd2, 1'b0);
        step(2'b11, 8'h81, 1'b0, 1'b0);
        expect_st("rot_reload", 8'h81, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(2'b01, 8'h00, 1'b0, 1'b0);
            expect_st("rot_left_seq", tbl_rot[i], 4'(i + 1), (i == 7));
        end
        step(2'b10, 8'h00, 1'b1, 1'b1);
        expect_st("rot_right_sat", 8'hC0, 4'd8, 1'b1);
`else
        // Shift left with zero fill, through saturation
        step(2'b11, 8'h81, 1'b0, 1'b0);
        expect_st("load_81", 8'h81, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(2'b01, 8'h00, 1'b0, 1'b0);
            expect_st("shl_seq", tbl_l[i], 4'(i + 1), (i == 7));
        end
        for (int i = 0; i < 2; i++) begin
            step(2'b01, 8'h00, 1'b0, 1'b0);
            expect_st("shl_saturate", 8'h00, 4'd8, 1'b1);
        end
        step(2'b00, 8'h00, 1'b0, 1'b0);
        expect_st("hold_done", 8'h00, 4'd8, 1'b1);

        // Shift right serial fill with ones
        step(2'b11, 8'h00, 1'b0, 1'b0);
        expect_st("load_00", 8'h00, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(2'b10, 8'h00, 1'b0, 1'b1);
            expect_st("shr_fill", tbl_r[i], 4'(i + 1), (i == 7));
        end
        step(2'b11, 8'h3C, 1'b0, 1'b0);
        expect_st("load_3c_clears", 8'h3C, 4'd0, 1'b0);

        // Mixed directions both count
        step(2'b01, 8'h00, 1'b1, 1'b0);
        expect_st("mix_left", 8'h79, 4'd1, 1'b0);
        step(2'b10, 8'h00, 1'b1, 1'b0);
        expect_st("mix_right", 8'h3C, 4'd2, 1'b0);

        // Asynchronous reset in the middle of a shift sequence
        step(2'b11, 8'hF0, 1'b0, 1'b0);
        expect_st("load_f0", 8'hF0, 4'd0, 1'b0);
        step(2'b01, 8'h00, 1'b0, 1'b0);
        expect_st("f0_shl1", 8'hE0, 4'd1, 1'b0);
        step(2'b01, 8'h00, 1'b0, 1'b0);
        expect_st("f0_shl2", 8'hC0, 4'd2, 1'b0);
        step(2'b01, 8'h00, 1'b0, 1'b0);
        expect_st("f0_shl3", 8'h80, 4'd3, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        expect_st("async_rst_during", 8'h00, 4'd0, 1'b0);
        rst = 1'b0;
        #1;
        expect_st("async_rst_after", 8'h00, 4'd0, 1'b0);
        mode = 2'b11; d = 8'h55;
        @(posedge clk);
        #1;
        expect_st("first_edge_after_rst", 8'h55, 4'd0, 1'b0);
`endif

        // Drain the scoreboard with a bound
        for (int i = 0; i < 100 && sb.size() > 0; i++) #1;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0 pending", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
